// File: rtl/m2vg_serial_stream.sv
// m2vg_serial_stream: streaming check-node min-finder for a min-sum LDPC decoder.
// It takes Wc sign-magnitude messages of one check row, one per handshake, and
// returns min1, min2, the index of min1 and the XOR of all sign bits.
// Stage p0 is the running accumulator. Stage p1 is the result register toward the
// consumer. A frame completes into p1 on the same edge as its last accept.
module m2vg_serial_stream #(
  parameter  int W  = 6,
  parameter  int Wc = 6,
  localparam int IW = $clog2(Wc)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_msg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-2:0]  min1,
  output logic [W-2:0]  min2,
  output logic [IW-1:0] idx,
  output logic          sgn
);

  localparam logic [IW-1:0] LAST = IW'(Wc - 1);

  logic [W-2:0]  mag;
  logic          sign;
  logic          last;
  logic          accept;

  logic [IW-1:0] cnt_p0;
  logic [W-2:0]  acc_min1_p0;
  logic [W-2:0]  acc_min2_p0;
  logic [IW-1:0] acc_idx_p0;
  logic          acc_sgn_p0;

  logic [W-2:0]  nxt_min1;
  logic [W-2:0]  nxt_min2;
  logic [IW-1:0] nxt_idx;
  logic          nxt_sgn;

  logic          vld_p1;
  logic [W-2:0]  res_min1_p1;
  logic [W-2:0]  res_min2_p1;
  logic [IW-1:0] res_idx_p1;
  logic          res_sgn_p1;

  assign mag  = in_msg[W-2:0];
  assign sign = in_msg[W-1];
  assign last = (cnt_p0 == LAST);

  // Only the frame-final message can stall. It stalls when the result register
  // still holds an unconsumed result that is not being taken this cycle.
  assign in_ready = !(last && vld_p1 && !out_ready);
  assign accept   = in_valid && in_ready && !clr;

  // Fold the incoming message into the running min1/min2/idx/sign.
  // Compares are strict, so on a tie the earlier index keeps min1.
  always_comb begin
    nxt_min1 = acc_min1_p0;
    nxt_min2 = acc_min2_p0;
    nxt_idx  = acc_idx_p0;
    nxt_sgn  = acc_sgn_p0 ^ sign;
    if (cnt_p0 == '0) begin
      nxt_min1 = mag;
      nxt_min2 = '1;
      nxt_idx  = '0;
      nxt_sgn  = sign;
    end else if (mag < acc_min1_p0) begin
      nxt_min2 = acc_min1_p0;
      nxt_min1 = mag;
      nxt_idx  = cnt_p0;
    end else if (mag < acc_min2_p0) begin
      nxt_min2 = mag;
    end
  end

  // ---- stage p0: frame counter and accumulators; clr aborts the partial frame
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_p0      <= '0;
      acc_min1_p0 <= '0;
      acc_min2_p0 <= '0;
      acc_idx_p0  <= '0;
      acc_sgn_p0  <= 1'b0;
    end else if (accept) begin
      cnt_p0      <= last ? '0 : cnt_p0 + 1'b1;
      acc_min1_p0 <= nxt_min1;
      acc_min2_p0 <= nxt_min2;
      acc_idx_p0  <= nxt_idx;
      acc_sgn_p0  <= nxt_sgn;
    end
  end

  // ---- stage p1: result register. It loads on frame completion and holds until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      res_min1_p1 <= '0;
      res_min2_p1 <= '0;
      res_idx_p1  <= '0;
      res_sgn_p1  <= 1'b0;
    end else if (accept && last) begin
      vld_p1      <= 1'b1;
      res_min1_p1 <= nxt_min1;
      res_min2_p1 <= nxt_min2;
      res_idx_p1  <= nxt_idx;
      res_sgn_p1  <= nxt_sgn;
    end else if (vld_p1 && out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign min1      = res_min1_p1;
  assign min2      = res_min2_p1;
  assign idx       = res_idx_p1;
  assign sgn       = res_sgn_p1;

endmodule

// File: tb/tb_m2vg_serial_stream.sv
// Testbench for m2vg_serial_stream. The bench runs directed frames and random frames.
// Expected results come from a frame-level model and go through a scoreboard queue.
// A monitor checks every presented result against that queue.
module tb_m2vg_serial_stream;

  localparam int W  = 6;
  localparam int WC = 6;
  localparam int IW = $clog2(WC);
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, in_ready, out_valid, out_ready, sgn;
  logic [W-1:0]  in_msg;
  logic [W-2:0]  min1, min2;
  logic [IW-1:0] idx;

  always #5 clk = ~clk;

  m2vg_serial_stream #(.W(W), .Wc(WC)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready),
    .min1(min1), .min2(min2), .idx(idx), .sgn(sgn)
  );

  typedef struct {int m1; int m2; int ix; int sg;} res_t;

  res_t exp_q[$];
  int   fr_mag[$];
  int   fr_sgn[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_consumed = 0;
  int   hold       = 0;
  bit   or_default = 1'b1;
  bit   rand_or    = 1'b0;

  int t1_mag[WC] = '{9, 3, 7, 3, 12, 1};
  int t1_sgn[WC] = '{1, 0, 0, 1, 0, 1};
  int t2_mag[WC] = '{4, 4, 8, 9, 10, 11};
  int t5_mag[WC] = '{2, 5, 6, 7, 8, 9};
  int zeros[WC]  = '{0, 0, 0, 0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model works on a whole frame. min1 is the smallest value, and idx is its first
  // position. min2 is the smallest of the remaining entries. sgn is the parity of the signs.
  function automatic res_t model(input int m[WC], input int s[WC]);
    res_t r;
    r.m1 = m[0];
    r.ix = 0;
    r.sg = 0;
    for (int i = 1; i < WC; i++)
      if (m[i] < r.m1) begin r.m1 = m[i]; r.ix = i; end
    r.m2 = MAXMAG + 1;
    for (int i = 0; i < WC; i++) begin
      if (i != r.ix && m[i] < r.m2) r.m2 = m[i];
      r.sg = r.sg ^ s[i];
    end
    return r;
  endfunction

  // Scoreboard monitor. It samples on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    res_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q[0];
        check("sb_min1", int'(min1), e.m1);
        check("sb_min2", int'(min2), e.m2);
        check("sb_idx",  int'(idx),  e.ix);
        check("sb_sgn",  int'(sgn),  e.sg);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge. Decide acceptance at the falling
  // edge. When a frame fills, its model result goes into the scoreboard.
  task automatic drive_cycle(input bit v, input int mag, input bit s, input bit c,
                             output bit acc);
    int a_m[WC];
    int a_s[WC];
    res_t r;
    in_valid = v;
    in_msg   = {s, (W-1)'(mag)};
    clr      = c;
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else if (rand_or) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = or_default;
    end
    @(negedge clk);
    acc = v && in_ready && !c;
    if (c) begin
      fr_mag.delete();
      fr_sgn.delete();
    end else if (acc) begin
      fr_mag.push_back(mag);
      fr_sgn.push_back(int'(s));
      if (fr_mag.size() == WC) begin
        for (int i = 0; i < WC; i++) begin
          a_m[i] = fr_mag[i];
          a_s[i] = fr_sgn[i];
        end
        r = model(a_m, a_s);
        exp_q.push_back(r);
        fr_mag.delete();
        fr_sgn.delete();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 1'b0, 1'b0, a);
  endtask

  task automatic send_msg(input int mag, input bit s, output int stalls);
    bit a;
    a = 1'b0;
    stalls = 0;
    for (int t = 0; t < 50; t++) begin
      drive_cycle(1'b1, mag, s, 1'b0, a);
      if (a) break;
      stalls++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic send_frame(input int m[WC], input int s[WC]);
    int st;
    for (int i = 0; i < WC; i++) send_msg(m[i], s[i][0], st);
  endtask

  function automatic int rand_mag();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(0, MAXMAG));
  endfunction

  task automatic send_random_frame(input int max_gap);
    int st;
    for (int i = 0; i < WC; i++) begin
      idle(int'($urandom_range(0, max_gap)));
      send_msg(rand_mag(), 1'($urandom_range(0, 1)), st);
    end
  endtask

  initial begin
    int st;
    int c0;
    bit a;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_msg = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_min1", int'(min1), 0);
    check("rst_min2", int'(min2), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_sgn", int'(sgn), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Basic frame: the result is visible one cycle after the sixth accept.
    send_frame(t1_mag, t1_sgn);
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_min1", int'(min1), 1);
    check("t1_min2", int'(min2), 3);
    check("t1_idx", int'(idx), 5);
    check("t1_sgn", int'(sgn), 1);
    idle(3);

    // Ties: the earlier index keeps min1, and the tie value becomes min2.
    send_frame(t2_mag, zeros);
    check("t2_min1", int'(min1), 4);
    check("t2_min2", int'(min2), 4);
    check("t2_idx", int'(idx), 0);
    check("t2_sgn", int'(sgn), 0);
    idle(3);

    // Back-pressure: the first result is held while the next frame streams.
    send_random_frame(0);
    hold = 8;
    for (int i = 0; i < WC - 1; i++) begin
      send_msg(MAXMAG, 1'($urandom_range(0, 1)), st);
      check("t3_early_stall", st, 0);
    end
    send_msg(MAXMAG, 1'($urandom_range(0, 1)), st);
    check("t3_final_stall", st, 3);
    check("t3_out_valid", int'(out_valid), 1);
    check("t3_min1", int'(min1), MAXMAG);
    check("t3_min2", int'(min2), MAXMAG);
    check("t3_idx", int'(idx), 0);
    idle(3);

    // Three back-to-back random frames with 0..2 cycle input gaps.
    c0 = n_consumed;
    for (int f = 0; f < 3; f++) send_random_frame(2);
    idle(4);
    check("t4_pulses", n_consumed - c0, 3);

    // clr aborts a partial frame. The accept offered on the same cycle is dropped.
    for (int i = 0; i < 3; i++) send_msg(rand_mag(), 1'($urandom_range(0, 1)), st);
    drive_cycle(1'b1, 0, 1'b1, 1'b1, a);
    check("t5_clr_accept", int'(a), 0);
    send_frame(t5_mag, zeros);
    check("t5_min1", int'(min1), 2);
    check("t5_min2", int'(min2), 5);
    check("t5_idx", int'(idx), 0);
    idle(3);

    // Reset mid-frame while a result is pending.
    or_default = 1'b0;
    send_random_frame(0);
    idle(2);
    for (int i = 0; i < 2; i++) send_msg(rand_mag(), 1'($urandom_range(0, 1)), st);
    check("t6_pending", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    fr_mag.delete();
    fr_sgn.delete();
    rst = 1'b0;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_min1", int'(min1), 0);
    check("t6_min2", int'(min2), 0);
    check("t6_idx", int'(idx), 0);
    check("t6_sgn", int'(sgn), 0);
    or_default = 1'b1;
    send_random_frame(1);
    idle(3);

    // Random soak: random gaps, random consumer stalls and occasional aborts.
    rand_or = 1'b1;
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < WC; i++) begin
        if ($urandom_range(0, 29) == 0)
          drive_cycle(1'($urandom_range(0, 1)), rand_mag(), 1'b0, 1'b1, a);
        idle(int'($urandom_range(0, 2)));
        send_msg(rand_mag(), 1'($urandom_range(0, 1)), st);
      end
    end
    rand_or = 1'b0;
    or_default = 1'b1;
    idle(20);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
